// File: rtl/scinstload.sv
// ---------------------------------------------------------------------------
// scinstload -- serial instruction loader with a word-addressed program RAM.
//
// A load is requested with a one-cycle start pulse while the loader is idle
// or finished. The requested word count is clamped to DEPTH. Program bytes
// then arrive on rx_data/rx_valid, are assembled big-endian into 32-bit words
// and are written to consecutive RAM words from address 0. While the load is
// in progress the CPU fetch port returns a nop.
//
// Handshake: a byte moves on a rising edge only when rx_valid and rx_ready
// are both 1. rx_valid may drop for any number of cycles; rx_ready depends
// only on the loader state, never on rx_valid.
//
// Optional feature, macro SCINSTLOAD_CKSUM_EN: after the last data word one
// extra checksum byte is accepted. err is set when the 8-bit sum of all bytes
// of the load plus that byte is non-zero. Without the macro err is tied to 0.
//
// Parameters:
//   DEPTH  RAM depth in 32-bit words, a power of two from 2 to 32
//   AW     word-address width, log2(DEPTH)
// Ports:
//   clk       clock, all state on the rising edge
//   reset     synchronous active-high reset (RAM contents are kept)
//   start     load request, honoured in IDLE and DONE only
//   len[5:0]  words to load, latched on an honoured start
//   rx_data   incoming program byte
//   rx_valid  rx_data valid
//   rx_ready  loader accepts a byte this cycle
//   a[31:0]   CPU fetch byte address
//   inst      RAM word at a[AW+1:2], or 0 while busy
//   busy      a load is in progress
//   done      the last load completed
//   err       checksum mismatch (0 unless SCINSTLOAD_CKSUM_EN)
// ---------------------------------------------------------------------------
module scinstload #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  len,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] a,
  output logic [31:0] inst,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef SCINSTLOAD_CKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2, CKSUM = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
`endif

  localparam logic [5:0] DEPTH_L = 6'(DEPTH);

  state_t      state;
  state_t      nx;
  logic [5:0]  len_q;
  logic [5:0]  word_cnt;
  logic [5:0]  len_clamp;
  // One bit wider than the RAM index so the count after the final word of a
  // full-depth load does not fold back onto address 0.
  logic [AW:0] waddr;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic [31:0] mem [DEPTH];

  logic accept;
  logic start_ok;
  logic last_byte;
  logic last_word;
  logic wr_en;

`ifdef SCINSTLOAD_CKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;
`endif

  always_comb begin
    len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
    accept    = rx_ready & rx_valid;
    start_ok  = start & ((state == IDLE) | (state == DONE));
    last_byte = (byte_cnt == 2'd3);
    last_word = ((word_cnt + 6'd1) == len_q);
    // reset wins over a byte arriving in the same cycle.
    wr_en     = accept & (state == LOAD) & last_byte & ~reset;

    nx = state;
    case (state)
      IDLE, DONE: begin
        if (start) nx = (len_clamp == 6'd0) ? DONE : LOAD;
      end
      LOAD: begin
        if (accept && last_byte && last_word) begin
`ifdef SCINSTLOAD_CKSUM_EN
          nx = CKSUM;
`else
          nx = DONE;
`endif
        end
      end
`ifdef SCINSTLOAD_CKSUM_EN
      CKSUM: begin
        if (accept) nx = DONE;
      end
`endif
      default: nx = IDLE;
    endcase
  end

  // State register plus registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_ready <= 1'b0;
      len_q    <= 6'd0;
      waddr    <= '0;
      word_cnt <= 6'd0;
      byte_cnt <= 2'd0;
      asm_q    <= 24'd0;
`ifdef SCINSTLOAD_CKSUM_EN
      sum_q    <= 8'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= nx;
`ifdef SCINSTLOAD_CKSUM_EN
      busy     <= (nx == LOAD) | (nx == CKSUM);
      rx_ready <= (nx == LOAD) | (nx == CKSUM);
`else
      busy     <= (nx == LOAD);
      rx_ready <= (nx == LOAD);
`endif
      done     <= (nx == DONE);

      if (start_ok) begin
        len_q    <= len_clamp;
        waddr    <= '0;
        word_cnt <= 6'd0;
        byte_cnt <= 2'd0;
        asm_q    <= 24'd0;
`ifdef SCINSTLOAD_CKSUM_EN
        sum_q    <= 8'd0;
        err_q    <= 1'b0;
`endif
      end else if (accept) begin
        if (state == LOAD) begin
          byte_cnt <= byte_cnt + 2'd1;
          // Only the first three bytes need holding; the fourth goes
          // straight into the RAM write data.
          asm_q    <= {asm_q[15:0], rx_data};
          if (last_byte) begin
            waddr    <= waddr + {{AW{1'b0}}, 1'b1};
            word_cnt <= word_cnt + 6'd1;
          end
`ifdef SCINSTLOAD_CKSUM_EN
          sum_q <= sum_q + rx_data;
`endif
        end
`ifdef SCINSTLOAD_CKSUM_EN
        if (state == CKSUM) begin
          err_q <= ((sum_q + rx_data) != 8'd0);
        end
`endif
      end
    end
  end

  // Program RAM: no reset, so words survive a reset or a short reload.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr[AW-1:0]] <= {asm_q, rx_data};
  end

  assign inst = busy ? 32'h0000_0000 : mem[a[AW+1:2]];

`ifdef SCINSTLOAD_CKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Address bits outside the word index are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{a[31:AW+2], a[1:0], waddr[AW]};

endmodule

// File: tb/tb_scinstload.sv
// ---------------------------------------------------------------------------
// tb_scinstload -- directed bench for scinstload (DEPTH=32, AW=5).
// A transaction-level model (byte queue, word array, load phase flags) is
// stepped by the driver after every clock edge; a compare process checks
// busy/done/rx_ready/err/inst against it on every falling edge. Literal
// expectations pin the model on the reference vectors.
// ---------------------------------------------------------------------------
module tb_scinstload;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
`ifdef SCINSTLOAD_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  len;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] a;
  logic [31:0] inst;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  scinstload #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .a(a), .inst(inst), .busy(busy), .done(done), .err(err)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit cnt_en = 1'b0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_loading = 1'b0;
  bit          m_ck = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  int          m_len = 0;
  int          m_widx = 0;
  logic [7:0]  m_sum = 8'd0;
  logic [7:0]  bq[$];
  logic [31:0] exp_q[$];   // words written by the current load, in order

  task automatic model_step(input bit rst, input bit st, input logic [5:0] ln,
                            input bit v, input logic [7:0] d);
    if (rst) begin
      m_loading = 1'b0; m_ck = 1'b0; m_done = 1'b0; m_err = 1'b0;
      bq.delete();
    end else if (st && !m_loading && !m_ck) begin
      m_len  = (int'(ln) > DEPTH) ? DEPTH : int'(ln);
      m_widx = 0;
      m_sum  = 8'd0;
      m_err  = 1'b0;
      bq.delete();
      exp_q.delete();
      m_loading = (m_len != 0);
      m_done    = (m_len == 0);
    end else if (m_loading && v) begin
      bq.push_back(d);
      m_sum = m_sum + d;
      if (bq.size() == 4) begin
        m_mem[m_widx]   = {bq[0], bq[1], bq[2], bq[3]};
        m_known[m_widx] = 1'b1;
        exp_q.push_back({bq[0], bq[1], bq[2], bq[3]});
        m_widx++;
        bq.delete();
        if (m_widx == m_len) begin
          m_loading = 1'b0;
          if (CK) m_ck = 1'b1;
          else    m_done = 1'b1;
        end
      end
    end else if (m_ck && v) begin
      m_err  = ((m_sum + d) != 8'd0);
      m_ck   = 1'b0;
      m_done = 1'b1;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit mb;
    mb = m_loading | m_ck;
    if (cnt_en && busy) busy_cnt++;
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, mb});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("rx_ready", {31'd0, rx_ready}, {31'd0, mb});
      check("err", {31'd0, err}, {31'd0, m_err});
      if (mb) check("inst_nop", inst, 32'h0);
      else if (m_known[a[AW+1:2]]) check("inst", inst, m_mem[a[AW+1:2]]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rst, input bit st, input logic [5:0] ln,
                       input bit v, input logic [7:0] d);
    reset = rst; start = st; len = ln; rx_valid = v; rx_data = d;
    @(posedge clk);
    model_step(rst, st, ln, v, d);
    #1;
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    drive(1'b0, 1'b0, 6'd0, 1'b1, d);
  endtask

  task automatic begin_load(input logic [5:0] ln);
    drive(1'b0, 1'b1, ln, 1'b0, 8'h00);
  endtask

  task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string name);
    a = addr;
    #2;
    check(name, inst, exp);
  endtask

  // Read back every word of the last load and compare with the scoreboard.
  task automatic drain();
    logic [31:0] w;
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      @(posedge clk);
      #1;
      peek(32'(i * 4), w, "mem_word");
      i++;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] t1 [8];
  logic [7:0] t3 [8];
  logic [7:0] t5 [6];

  initial begin
    t1 = '{8'h3c, 8'h01, 8'h00, 8'h00, 8'h34, 8'h24, 8'h00, 8'h50};
    t3 = '{8'h0b, 8'had, 8'hf0, 8'h0d, 8'hca, 8'hfe, 8'hba, 8'hbe};
    t5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    a = 32'h0; reset = 1'b1; start = 1'b0; len = 6'd0; rx_valid = 1'b0; rx_data = 8'h00;

    drive(1'b1, 1'b0, 6'd0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 6'd3, 1'b1, 8'haa);   // reset beats start/rx_valid
    chk_en = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Reference load, rx_valid held high.
    begin_load(6'd2);
    busy_cnt = 0; cnt_en = 1'b1;
    for (int i = 0; i < 8; i++) send(t1[i]);
    check("t1_done", {31'd0, done}, 32'd1);
    drive(1'b0, 1'b0, 6'd0, 1'b0, 8'h00);
    cnt_en = 1'b0;
    check("t1_busy_cycles", 32'(busy_cnt), 32'd8);
    peek(32'h0, 32'h3c010000, "t1_w0");
    peek(32'h4, 32'h34240050, "t1_w1");
    drain();

    // Same load from DONE, rx_valid toggling.
    begin_load(6'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t2_not_done", {31'd0, done}, 32'd0);
      send(t1[i]);
      if (i == 7) check("t2_done", {31'd0, done}, 32'd1);
      drive(1'b0, 1'b0, 6'd0, 1'b0, 8'hff);
    end
    peek(32'h0, 32'h3c010000, "t2_w0");
    peek(32'h4, 32'h34240050, "t2_w1");
    drain();

    // nop fetch while busy; start mid-load is ignored.
    begin_load(6'd2);
    send(t3[0]); send(t3[1]);
    peek(32'h0, 32'h0, "t3_nop");
    drive(1'b0, 1'b1, 6'd1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 6'd0, 1'b1, t3[2]);
    for (int i = 3; i < 8; i++) send(t3[i]);
    peek(32'h0, 32'h0badf00d, "t3_w0");
    peek(32'h4, 32'hcafebabe, "t3_w1");
    drain();

    // len=40 clamps to 32 words.
    begin_load(6'd40);
    for (int i = 0; i < 128; i++) begin
      if (i == 127) check("t4_not_done", {31'd0, done}, 32'd0);
      send(8'((i * 37 + 11) & 255));
    end
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_words", 32'(exp_q.size()), 32'd32);
    for (int i = 0; i < 4; i++) send(8'h5a);
    check("t4_rx_ready", {31'd0, rx_ready}, 32'd0);
    peek(32'h0, 32'h0b30557a, "t4_w0");
    peek(32'h7c, 32'hf71c4166, "t4_w31");
    drain();

    // Reset after six bytes of a two-word load.
    begin_load(6'd2);
    for (int i = 0; i < 6; i++) send(t5[i]);
    drive(1'b1, 1'b1, 6'd2, 1'b1, 8'h77);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    peek(32'h0, 32'h11223344, "t5_w0");
    peek(32'h4, 32'h9fc4e90e, "t5_w1_old");
    send(8'h99);   // ignored in IDLE
    drain();

    // len=0 goes straight to DONE.
    begin_load(6'd0);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    peek(32'h0, 32'h11223344, "t6_w0");

`ifdef SCINSTLOAD_CKSUM_EN
    // Checksum byte: 01+02+03+04+F6 = 0 mod 256.
    begin_load(6'd1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("t7_ck_busy", {31'd0, busy}, 32'd1);
    send(8'hf6);
    check("t7_done", {31'd0, done}, 32'd1);
    check("t7_err0", {31'd0, err}, 32'd0);
    begin_load(6'd1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'hf7);
    check("t7_err1", {31'd0, err}, 32'd1);
    drive(1'b0, 1'b0, 6'd0, 1'b0, 8'h00);
    check("t7_err_hold", {31'd0, err}, 32'd1);
    begin_load(6'd0);
    check("t7_err_clr", {31'd0, err}, 32'd0);
    peek(32'h0, 32'h01020304, "t7_w0");
    drain();
`endif

    drive(1'b0, 1'b0, 6'd0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 6'd0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scinstload.md
SCINSTLOAD -- requirements
Module: scinstload

Interface
REQ-001 Parameter DEPTH, default 32, is the instruction RAM depth in 32-bit words and SHALL be a power of two from 2 to 32.
REQ-002 Parameter AW, default 5, is the word-address width and SHALL equal log2(DEPTH).
REQ-003 clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  one-cycle request to begin a load; sampled in IDLE or DONE only.
REQ-006 len  in  6  number of words to load, latched on an accepted start.
REQ-007 rx_data  in  8  incoming program byte.
REQ-008 rx_valid  in  1  rx_data is valid.
REQ-009 rx_ready  out  1  loader accepts a byte this cycle.
REQ-010 a  in  32  CPU fetch byte address.
REQ-011 inst  out  32  instruction at word a[AW+1:2].
REQ-012 busy  out  1  a load is in progress; the CPU is held.
REQ-013 done  out  1  the last load completed.
REQ-014 err  out  1  checksum mismatch; exists only under REQ-036.

Function
REQ-015 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-016 IDLE, start=1: latch len clamped to DEPTH; go to DONE if the clamped len is 0, otherwise go to LOAD.
REQ-017 DONE, start=1: behave as REQ-016, so a reload is possible; start in LOAD SHALL be ignored.
REQ-018 rx_ready SHALL be 1 only in LOAD; a byte is accepted only when rx_valid and rx_ready are both 1.
REQ-019 Accepted bytes SHALL assemble big-endian: the first byte of a word lands in bits 31:24 and the fourth in bits 7:0.
REQ-020 On the edge that accepts the fourth byte, the assembled word SHALL be written to mem[waddr]; waddr and word_cnt then increment.
REQ-021 waddr SHALL start at 0 on every load and SHALL never wrap, because len is clamped to DEPTH.
REQ-022 When the written word is number len (word_cnt = len-1 before the increment), the FSM SHALL go to DONE on the same edge.
REQ-023 Cycles with rx_valid=0 SHALL cause no state change; gaps between bytes are unbounded.
REQ-024 busy = (state == LOAD); done = (state == DONE); both are registered state decodes.
REQ-025 The read is combinational: inst = mem[a[AW+1:2]] when busy=0, and inst = 32'h00000000 (nop) when busy=1.
REQ-026 Words not written by the current load SHALL keep their previous contents.
REQ-027 Load latency: done SHALL rise on the cycle after the edge that accepts the final byte.

Reset
REQ-028 reset SHALL override start and rx_valid in the same cycle.
REQ-029 reset SHALL return the FSM to IDLE.
REQ-030 reset SHALL clear waddr, word_cnt, the byte counter and the assembly register.
REQ-031 Output values after reset: busy=0, done=0, rx_ready=0, err=0.
REQ-032 reset SHALL NOT clear the memory array; its contents are undefined after power-up.
REQ-033 Reset during LOAD: completed words remain written and the partially assembled word is discarded.

Configuration
REQ-034 Macro SCINSTLOAD_CKSUM_EN selects the checksum feature.
REQ-035 When SCINSTLOAD_CKSUM_EN is undefined: no checksum byte is expected, err is tied to 0, and the FSM has only the states of REQ-015.
REQ-036 When SCINSTLOAD_CKSUM_EN is defined: an 8-bit running sum of every accepted byte is kept, cleared on start.
REQ-037 Under REQ-036, after the last data word the FSM SHALL enter a CKSUM state with busy=1 and rx_ready=1, and accept exactly one more byte.
REQ-038 Under REQ-036, on that byte: go to DONE; err is set if (sum + byte) mod 256 != 0, otherwise cleared.
REQ-039 Under REQ-036, err SHALL hold until the next accepted start or reset.
REQ-040 Under REQ-036, with len=0 the FSM SHALL go straight to DONE with err=0 and no checksum byte.

Verification
REQ-041 reset, then start with len=2, bytes 3c 01 00 00 34 24 00 50 with rx_valid always 1 -> busy high for 8 cycles; done=1; a=0 gives inst=3c010000; a=4 gives inst=34240050.
REQ-042 Same load with rx_valid toggling 1,0,1,0 -> identical memory contents; done rises one cycle after the 8th accepted byte.
REQ-043 len=40 with 128 bytes -> exactly 32 words written; done after byte 128; rx_ready=0 afterwards.
REQ-044 Reset asserted after 6 bytes of a len=2 load of 11223344 55667788 -> IDLE, busy=0; a=0 gives 11223344; a=4 keeps its old value.
REQ-045 During busy, a=0 gives inst=00000000; start pulsed mid-LOAD changes nothing.
REQ-046 Under SCINSTLOAD_CKSUM_EN, len=1, bytes 01 02 03 04 then F6 -> done=1 and err=0; the same load with checksum byte F7 -> err=1.
